alu_seq_nb: RTL and testbench

ALU_SEQ_NB -- requirements
Module: alu_seq_nb

---
 rtl/alu_seq_nb_if.sv | 30 +++
 rtl/alu_seq_nb.sv | 158 +++++++++++++++
 tb/tb_alu_seq_nb.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_nb_if.sv
// Operation/result handshake bundle for alu_seq_nb.
// The producer side uses master and the ALU uses slave.
interface alu_seq_nb_if #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_f;
  logic             carry_mask;
  logic [3:0]       sf_in;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SHW-1:0]   shamt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d;
  logic [3:0]       sf_out;
  logic             busy;

  modport master (
    output in_valid, alu_f, carry_mask, sf_in, a, b, shamt, out_ready,
    input  in_ready, out_valid, d, sf_out, busy
  );

  modport slave (
    input  in_valid, alu_f, carry_mask, sf_in, a, b, shamt, out_ready,
    output in_ready, out_valid, d, sf_out, busy
  );
endinterface

// File: rtl/alu_seq_nb.sv
// ALU with a valid/ready front end. Most opcodes finish in one cycle.
// Shifts by shamt>0 and multiply iterate one step per cycle.
module alu_seq_nb #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_seq_nb_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ITER, HOLD} state_t;
  typedef enum logic [1:0] {OP_ROR, OP_ROL, OP_MUL} iop_t;
  localparam int CW = SHW + 1;

  state_t           state, state_nxt;
  iop_t             w_op;
  logic [WIDTH-1:0] d_q, w_d, w_lo, w_a;
  logic [3:0]       sf_q;
  logic             out_valid_q, w_c, w_cm, w_v;
  logic [CW-1:0]    cnt;
  logic             accept, is_iter, last, load;
  logic [WIDTH-1:0] r_d, s_d, s_lo, it_d, ld_d;
  logic [3:0]       r_sf, it_sf, ld_sf;
  logic [WIDTH:0]   sum, msum;
  logic             cin, r_c, r_v, s_c, ins;

  assign bus.in_ready  = (state == IDLE) & (~out_valid_q | bus.out_ready);
  assign bus.out_valid = out_valid_q;
  assign bus.d         = d_q;
  assign bus.sf_out    = sf_q;
  assign bus.busy      = (state == ITER);

  assign accept  = bus.in_valid & bus.in_ready;
  assign is_iter = (bus.alu_f == 4'hC) |
                   (((bus.alu_f == 4'hA) | (bus.alu_f == 4'hB)) & (bus.shamt != '0));
  assign last    = (state == ITER) & (cnt == CW'(1));
  assign load    = (accept & ~is_iter) | last;
  assign ld_d    = last ? it_d  : r_d;
  assign ld_sf   = last ? it_sf : r_sf;

  // Single-cycle result, computed straight from the presented operands.
  always_comb begin
    cin = bus.carry_mask & bus.sf_in[0];
    sum = '0;
    r_d = '0;
    r_c = bus.sf_in[0];
    r_v = bus.sf_in[1];
    case (bus.alu_f)
      4'h0: begin
        sum = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, cin};
        r_d = sum[WIDTH-1:0];
        r_c = sum[WIDTH];
        r_v = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) & (r_d[WIDTH-1] != bus.a[WIDTH-1]);
      end
      4'h1: r_d = bus.b + WIDTH'(1);
      4'h2: begin
        sum = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, ~cin};
        r_d = sum[WIDTH-1:0];
        r_c = sum[WIDTH];
        r_v = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) & (r_d[WIDTH-1] != bus.a[WIDTH-1]);
      end
      4'h3: r_d = bus.b - WIDTH'(1);
      4'h4: r_d = bus.a & bus.b;
      4'h5: r_d = bus.a | bus.b;
      4'h6: r_d = bus.a ^ bus.b;
      4'h7: r_d = bus.b;
      4'h8: r_d = {{(WIDTH-8){bus.b[7]}}, bus.b[7:0]};
      4'h9: r_d = {bus.b[WIDTH/2-1:0], bus.b[WIDTH-1:WIDTH/2]};
      4'hA, 4'hB: r_d = bus.b;
      default: r_d = '0;
    endcase
    r_sf = {r_d[WIDTH-1], r_d == '0, r_v, r_c};
    if ((bus.alu_f == 4'hA) | (bus.alu_f == 4'hB)) r_sf[3] = 1'b0;
    if (bus.alu_f == 4'hD) r_sf = '0;
    if ((bus.alu_f == 4'hE) | (bus.alu_f == 4'hF)) r_sf = bus.sf_in;
  end

  // One iteration step; for MUL, w_d is the high half and w_lo the multiplier.
  always_comb begin
    ins   = w_cm & w_c;
    s_d   = w_d;
    s_c   = w_c;
    s_lo  = w_lo;
    msum  = '0;
    case (w_op)
      OP_ROR: begin s_d = {ins, w_d[WIDTH-1:1]}; s_c = w_d[0]; end
      OP_ROL: begin s_d = {w_d[WIDTH-2:0], ins}; s_c = w_d[WIDTH-1]; end
      default: begin
        msum = {1'b0, w_d} + (w_lo[0] ? {1'b0, w_a} : '0);
        s_d  = msum[WIDTH:1];
        s_lo = {msum[0], w_lo[WIDTH-1:1]};
      end
    endcase
    if (w_op == OP_MUL) begin
      it_d  = s_lo;
      it_sf = {s_lo[WIDTH-1], s_lo == '0, 1'b0, |s_d};
    end else begin
      it_d  = s_d;
      it_sf = {1'b0, s_d == '0, w_v, s_c};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept & is_iter)                  state_nxt = ITER;
        else if (out_valid_q & ~bus.out_ready) state_nxt = HOLD;
      end
      ITER:    if (last)          state_nxt = IDLE;
      HOLD:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      d_q         <= '0;
      sf_q        <= '0;
      w_d         <= '0;
      w_lo        <= '0;
      w_a         <= '0;
      w_c         <= 1'b0;
      w_cm        <= 1'b0;
      w_v         <= 1'b0;
      w_op        <= OP_ROR;
      cnt         <= '0;
    end else begin
      if (out_valid_q & bus.out_ready) out_valid_q <= 1'b0;
      if (load) begin
        out_valid_q <= 1'b1;
        d_q         <= ld_d;
        sf_q        <= ld_sf;
      end
      if (accept & is_iter) begin
        w_d  <= (bus.alu_f == 4'hC) ? '0 : bus.b;
        w_lo <= bus.b;
        w_a  <= bus.a;
        w_c  <= bus.sf_in[0];
        w_cm <= bus.carry_mask;
        w_v  <= bus.sf_in[1];
        w_op <= (bus.alu_f == 4'hC) ? OP_MUL : ((bus.alu_f == 4'hA) ? OP_ROR : OP_ROL);
        cnt  <= (bus.alu_f == 4'hC) ? CW'(WIDTH) : {1'b0, bus.shamt};
      end else if (state == ITER) begin
        w_d  <= s_d;
        w_lo <= s_lo;
        w_c  <= s_c;
        cnt  <= cnt - CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_alu_seq_nb.sv
// Scoreboarded bench for alu_seq_nb: directed corner cases plus random traffic
// with random back-pressure at WIDTH=16, and a WIDTH=32 instance.
module tb_alu_seq_nb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_seq_nb_if #(.WIDTH(16), .SHW(4)) bus16();
  alu_seq_nb_if #(.WIDTH(32), .SHW(5)) bus32();

  alu_seq_nb #(.WIDTH(16), .SHW(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  alu_seq_nb #(.WIDTH(32), .SHW(5)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

  typedef struct packed { logic [3:0] sf; logic [31:0] d; } exp_t;
  exp_t q16[$];
  exp_t q32[$];
  exp_t e16, e32;
  int   tests = 0;
  int   fails = 0;
  bit   bp_rand = 1'b0;
  logic or_fixed = 1'b1;

  task automatic check(input string name, input logic [35:0] got, input logic [35:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Reference: plain arithmetic on the operand values, result as {N,Z,V,C, d}.
  function automatic logic [35:0] model(input int w, input logic [3:0] op, input logic cm,
                                         input logic [3:0] sf, input longint a, input longint b,
                                         input int sh);
    longint m    = (longint'(1) << w) - 1;
    longint half = longint'(1) << (w - 1);
    longint m1   = (longint'(1) << (w + 1)) - 1;
    longint sa   = (a >= half) ? a - (m + 1) : a;
    longint sb   = (b >= half) ? b - (m + 1) : b;
    longint cin  = (cm && sf[0]) ? 1 : 0;
    longint r = 0, s = 0, x = 0;
    logic [63:0] p;
    logic n, z, v, c;
    v = sf[1];
    c = sf[0];
    case (op)
      4'h0: begin r = a + b + cin; c = (r > m); s = sa + sb + cin; v = (s >= half) || (s < -half); end
      4'h1: r = b + 1;
      4'h2: begin r = a - b - cin; c = (r >= 0); s = sa - sb - cin; v = (s >= half) || (s < -half); end
      4'h3: r = b - 1;
      4'h4: r = a & b;
      4'h5: r = a | b;
      4'h6: r = a ^ b;
      4'h7: r = b;
      4'h8: r = b[7] ? ((b & 'hFF) | (m & ~longint'('hFF))) : (b & 'hFF);
      4'h9: r = ((b & ((longint'(1) << (w / 2)) - 1)) << (w / 2)) | (b >> (w / 2));
      4'hA: begin
        if (sh == 0) r = b;
        else if (cm) begin
          x = (longint'(c) << w) | b;
          x = ((x >> sh) | (x << (w + 1 - sh))) & m1;
          r = x; c = x[w];
        end else begin r = b >> sh; c = b[sh - 1]; end
      end
      4'hB: begin
        if (sh == 0) r = b;
        else if (cm) begin
          x = (longint'(c) << w) | b;
          x = ((x << sh) | (x >> (w + 1 - sh))) & m1;
          r = x; c = x[w];
        end else begin r = b << sh; c = b[w - sh]; end
      end
      4'hC: begin p = a * b; r = p; c = ((p >> w) != 0); v = 1'b0; end
      4'hD: return '0;
      default: return {sf, 32'h0};
    endcase
    r = r & m;
    n = (op == 4'hA || op == 4'hB) ? 1'b0 : r[w - 1];
    z = (r == 0);
    return {n, z, v, c, r[31:0]};
  endfunction

  // Output handshake driver: fixed level or random back-pressure.
  always begin
    bus16.out_ready = bp_rand ? ($urandom_range(0, 3) != 0) : or_fixed;
    @(negedge clk);
  end

  // Monitors: pop one expectation per completed output transfer.
  always begin
    @(negedge clk);
    #2;
    if (rst_n && bus16.out_valid && bus16.out_ready) begin
      if (q16.size() == 0) check("res16_unexpected", {bus16.sf_out, 16'h0, bus16.d}, 36'h0_dead_beef);
      else begin
        e16 = q16.pop_front();
        check("res16", {bus16.sf_out, 16'h0, bus16.d}, e16);
      end
    end
  end

  always begin
    @(negedge clk);
    #2;
    if (rst_n && bus32.out_valid && bus32.out_ready) begin
      if (q32.size() == 0) check("res32_unexpected", {bus32.sf_out, bus32.d}, 36'h0_dead_beef);
      else begin
        e32 = q32.pop_front();
        check("res32", {bus32.sf_out, bus32.d}, e32);
      end
    end
  end

  task automatic issue16(input logic [3:0] op, input logic cm, input logic [3:0] sf,
                         input logic [15:0] a, input logic [15:0] b, input logic [3:0] sh);
    int n;
    n = 0;
    @(negedge clk);
    bus16.alu_f = op; bus16.carry_mask = cm; bus16.sf_in = sf;
    bus16.a = a; bus16.b = b; bus16.shamt = sh; bus16.in_valid = 1'b1;
    #1;
    while (!bus16.in_ready && n < 200) begin @(negedge clk); #1; n++; end
    if (!bus16.in_ready) begin
      check("accept16_timeout", 36'(bus16.in_ready), 36'd1);
      bus16.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    q16.push_back(model(16, op, cm, sf, a, b, int'(sh)));
    #1 bus16.in_valid = 1'b0;
  endtask

  task automatic issue32(input logic [3:0] op, input logic cm, input logic [3:0] sf,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
    int n;
    n = 0;
    @(negedge clk);
    bus32.alu_f = op; bus32.carry_mask = cm; bus32.sf_in = sf;
    bus32.a = a; bus32.b = b; bus32.shamt = sh; bus32.in_valid = 1'b1;
    #1;
    while (!bus32.in_ready && n < 200) begin @(negedge clk); #1; n++; end
    if (!bus32.in_ready) begin
      check("accept32_timeout", 36'(bus32.in_ready), 36'd1);
      bus32.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    q32.push_back(model(32, op, cm, sf, a, b, int'(sh)));
    #1 bus32.in_valid = 1'b0;
  endtask

  // Counts negedges until out_valid, and how many of them showed busy.
  task automatic wait_res(output int lat, output int nb);
    lat = 0;
    nb  = 0;
    while (lat < 100) begin
      @(negedge clk);
      #1;
      lat++;
      if (bus16.out_valid) break;
      if (bus16.busy) nb++;
    end
    if (!bus16.out_valid) check("result_timeout", 36'(bus16.out_valid), 36'd1);
  endtask

  initial begin
    int lat, nb, n;
    bus16.in_valid = 1'b0; bus16.alu_f = '0; bus16.carry_mask = 1'b0; bus16.sf_in = '0;
    bus16.a = '0; bus16.b = '0; bus16.shamt = '0;
    bus32.in_valid = 1'b0; bus32.alu_f = '0; bus32.carry_mask = 1'b0; bus32.sf_in = '0;
    bus32.a = '0; bus32.b = '0; bus32.shamt = '0; bus32.out_ready = 1'b1;

    @(negedge clk);
    #1;
    check("reset_outputs", {bus16.out_valid, bus16.busy, bus16.sf_out, 14'h0, bus16.d}, 36'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("in_ready_after_reset", 36'(bus16.in_ready), 36'd1);

    // Carry-in add, single-cycle latency
    issue16(4'h0, 1'b1, 4'h1, 16'hFFFF, 16'h0001, 4'h0);
    wait_res(lat, nb);
    check("add_latency", 36'(lat), 36'd1);
    check("add_d", 36'(bus16.d), 36'h0001);

    issue16(4'h2, 1'b0, 4'h0, 16'h8000, 16'h0001, 4'h0);
    wait_res(lat, nb);
    check("sub_ovf_flags", 36'(bus16.sf_out), 36'b0011);

    issue16(4'hA, 1'b1, 4'h1, 16'h0000, 16'h0003, 4'h2);
    wait_res(lat, nb);
    check("ror_busy_cycles", 36'(nb), 36'd2);
    check("ror_d", 36'(bus16.d), 36'hC000);

    // Multiply held under back-pressure
    or_fixed = 1'b0;
    issue16(4'hC, 1'b0, 4'h0, 16'h0100, 16'h0100, 4'h0);
    wait_res(lat, nb);
    check("mul_busy_cycles", 36'(nb), 36'd16);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("mul_hold", {bus16.in_ready, bus16.out_valid, bus16.sf_out, bus16.d}, {2'b01, 4'b0101, 16'h0000});
    end
    or_fixed = 1'b1;
    @(negedge clk);
    #3;
    @(negedge clk);
    #1;
    check("mul_released", 36'(bus16.out_valid), 36'd0);

    // Reset in the middle of a multiply
    issue16(4'hC, 1'b0, 4'h0, 16'h1234, 16'h5678, 4'h0);
    repeat (4) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", {bus16.out_valid, bus16.busy, bus16.sf_out, 14'h0, bus16.d}, 36'h0);
    q16.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midreset_in_ready", 36'(bus16.in_ready), 36'd1);
    issue16(4'h0, 1'b0, 4'h0, 16'h0002, 16'h0003, 4'h0);
    wait_res(lat, nb);
    check("post_reset_add", 36'(bus16.d), 36'h0005);

    // Random traffic with back-pressure, held in_valid during ITER/HOLD
    bp_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue16(4'($urandom_range(0, 15)), 1'($urandom), 4'($urandom), 16'($urandom),
              16'($urandom), 4'($urandom));
    end
    bp_rand = 1'b0;
    n = 0;
    while ((q16.size() != 0 || bus16.out_valid) && n < 200) begin @(negedge clk); #3; n++; end
    check("drain16", 36'(q16.size()), 36'd0);

    // Wider instance
    issue32(4'h9, 1'b0, 4'h0, 32'h0, 32'h12345678, 5'd0);
    issue32(4'h8, 1'b0, 4'h0, 32'h0, 32'h00000080, 5'd0);
    issue32(4'h0, 1'b1, 4'h1, 32'hFFFFFFFF, 32'h00000001, 5'd0);
    issue32(4'hB, 1'b0, 4'h2, 32'h0, 32'h80000001, 5'd31);
    issue32(4'hC, 1'b0, 4'h0, 32'h00012345, 32'h00054321, 5'd0);
    n = 0;
    while ((q32.size() != 0 || bus32.out_valid) && n < 200) begin @(negedge clk); #3; n++; end
    check("drain32", 36'(q32.size()), 36'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
